// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: 4-bit opcode map and FSM states.
// The low eight encodings keep the original 3-bit ALU meanings with a leading 0.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NOT  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SLL1 = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_BNE  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLLV = 4'b1011;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_RSVD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Purely combinational evaluation of every single-cycle ALU op.
// MUL and the reserved code produce all-zero outputs here; MUL is handled
// by the iterative datapath in the top level.
module alu_seq_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SHW-1:0]   sh_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;

    // Only the low SHW bits of b form the shift amount.
    assign sh_s   = b[SHW-1:0];
    assign sum_s  = a + b;
    assign diff_s = a - b;

    // Opcode decode; every output gets a defined value on every code.
    always_comb begin
        f    = ZERO_W;
        ovf  = 1'b0;
        zero = 1'b0;
        case (sel)
            OP_ADD: begin
                f   = sum_s;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  f = ~b;
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_SLTU: f = (a < b) ? ONE_W : ZERO_W;
            OP_SLL1: f = {a[WIDTH-2:0], 1'b0};
            OP_BEQ: begin
                f    = ZERO_W;
                zero = (a == b);
            end
            OP_BNE: begin
                f    = ZERO_W;
                zero = (a != b);
            end
            OP_SUB: begin
                f   = diff_s;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  f = a ^ b;
            OP_SLT:  f = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
            OP_SLLV: f = a << sh_s;
            OP_SRL:  f = a >> sh_s;
            OP_SRA:  f = $signed(a) >>> sh_s;
            OP_MUL:  f = ZERO_W;
            OP_RSVD: f = ZERO_W;
            default: begin
                f    = ZERO_W;
                ovf  = 1'b0;
                zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU. Single-cycle ops are registered on accept;
// MUL runs an unsigned shift-add loop for WIDTH cycles. Results are held
// in output registers until the consumer takes them.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    state_t state_r;
    state_t state_nxt_s;

    logic             accept_s;
    logic             is_mul_s;
    logic             last_s;
    logic [WIDTH-1:0] comb_f_s;
    logic             comb_ovf_s;
    logic             comb_zero_s;
    logic [WIDTH-1:0] acc_nxt_s;

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [SHW-1:0]   cnt_r;
    logic [WIDTH-1:0] f_r;
    logic             ovf_r;
    logic             zero_r;

    alu_seq_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a    (a),
        .b    (b),
        .sel  (sel),
        .f    (comb_f_s),
        .ovf  (comb_ovf_s),
        .zero (comb_zero_s)
    );

    assign is_mul_s  = (sel == OP_MUL);
    assign last_s    = (cnt_r == CNT_LAST);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == DONE);
    assign f         = f_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

    // State register; reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and ready logic; DONE forwards out_ready so a new op can
    // be accepted on the same cycle the current result is taken.
    always_comb begin
        state_nxt_s = state_r;
        in_ready    = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt_s = is_mul_s ? BUSY : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                in_ready = 1'b0;
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_nxt_s = is_mul_s ? BUSY : DONE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                in_ready    = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // One shift-add step: add the multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_nxt_s = acc_r;
        if (mplier_r[0]) begin
            acc_nxt_s = acc_r + mcand_r;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Operand/multiplier datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= ZERO_W;
            mplier_r <= ZERO_W;
            acc_r    <= ZERO_W;
            cnt_r    <= {SHW{1'b0}};
            f_r      <= ZERO_W;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else if (accept_s) begin
            if (is_mul_s) begin
                mcand_r  <= a;
                mplier_r <= b;
                acc_r    <= ZERO_W;
                cnt_r    <= {SHW{1'b0}};
            end else begin
                f_r    <= comb_f_s;
                ovf_r  <= comb_ovf_s;
                zero_r <= comb_zero_s;
            end
        end else if (state_r == BUSY) begin
            acc_r    <= acc_nxt_s;
            mcand_r  <= mcand_r << 1'b1;
            mplier_r <= mplier_r >> 1'b1;
            cnt_r    <= cnt_r + CNT_ONE;
            if (last_s) begin
                f_r    <= acc_nxt_s;
                ovf_r  <= 1'b0;
                zero_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued when an op is
// driven and compared when out_valid appears, along with result latency.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] f;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   sel = 4'b0000;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] f;
    logic         ovf;
    logic         zero;

    res_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: written from the opcode table, not the RTL.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] s);
        res_t        r;
        logic [63:0] p;
        int          sh;
        r  = '0;
        sh = int'(y[4:0]);
        p  = 64'(x) * 64'(y);
        case (s)
            OP_ADD: begin
                r.f   = x + y;
                r.ovf = (x[W-1] == y[W-1]) && (r.f[W-1] != x[W-1]);
            end
            OP_NOT:  r.f = ~y;
            OP_AND:  r.f = x & y;
            OP_OR:   r.f = x | y;
            OP_SLTU: r.f = (x < y) ? 32'd1 : 32'd0;
            OP_SLL1: r.f = x * 32'd2;
            OP_BEQ:  r.zero = (x == y);
            OP_BNE:  r.zero = (x != y);
            OP_SUB: begin
                r.f   = x + ~y + 32'd1;
                r.ovf = (x[W-1] != y[W-1]) && (r.f[W-1] != x[W-1]);
            end
            OP_XOR:  r.f = x ^ y;
            OP_SLT:  r.f = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_SLLV: r.f = x << sh;
            OP_SRL:  r.f = x >> sh;
            OP_SRA: begin
                r.f = x >> sh;
                if (x[W-1]) begin
                    for (int i = 0; i < sh; i++) r.f[W-1-i] = 1'b1;
                end
            end
            OP_MUL:  r.f = p[W-1:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Present an op and hold it until accepted; returns one cycle after the accept edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [3:0] ts);
        int n;
        n = 0;
        a = ta;
        b = tb_v;
        sel = ts;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check_val("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for out_valid (bounded), check latency, pop and compare the result.
    task automatic expect_res(input string tag, input int lat, input bit mul);
        int   n;
        res_t e;
        n = 1;
        while (!out_valid && n < 200) begin
            if (mul) check_val({tag, "_busy_ready"}, in_ready, 0);
            tick();
            n++;
        end
        check_val({tag, "_latency"}, n, lat);
        check_val({tag, "_sb_nonempty"}, (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({tag, "_f"}, f, e.f);
            check_val({tag, "_ovf"}, ovf, e.ovf);
            check_val({tag, "_zero"}, zero, e.zero);
        end
    endtask

    task automatic op_k(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [3:0] ts,
                        input logic [W-1:0] ef, input logic eo, input logic ez, input string tag);
        res_t e;
        e.f = ef;
        e.ovf = eo;
        e.zero = ez;
        sb_q.push_back(e);
        send(ta, tb_v, ts);
        expect_res(tag, (ts == OP_MUL) ? W + 1 : 1, ts == OP_MUL);
        tick();
    endtask

    task automatic op_m(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [3:0] ts, input string tag);
        res_t e;
        e = model(ta, tb_v, ts);
        op_k(ta, tb_v, ts, e.f, e.ovf, e.zero, tag);
    endtask

    initial begin
        int hi_cnt;
        res_t e;

        // Reset state, both during and after reset.
        tick();
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        #3 rst_n = 1'b1;
        tick();
        check_val("post_rst_out_valid", out_valid, 0);
        check_val("post_rst_f", f, 0);
        check_val("post_rst_ovf", ovf, 0);
        check_val("post_rst_zero", zero, 0);
        check_val("post_rst_in_ready", in_ready, 1);

        // Directed values from the opcode table.
        op_k(32'h7FFF_FFFF, 32'h1, OP_ADD, 32'h8000_0000, 1'b1, 1'b0, "add_ovf");
        op_k(32'h8000_0000, 32'h1, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b0, "sub_ovf");
        op_k(32'hFFFF_FFFF, 32'h1, OP_SLT, 32'h1, 1'b0, 1'b0, "slt");
        op_k(32'hFFFF_FFFF, 32'h1, OP_SLTU, 32'h0, 1'b0, 1'b0, "sltu");
        op_k(32'h8000_0010, 32'h24, OP_SRL, 32'h0800_0001, 1'b0, 1'b0, "srl");
        op_k(32'h8000_0010, 32'h24, OP_SRA, 32'hF800_0001, 1'b0, 1'b0, "sra");
        op_k(32'h8000_0010, 32'h24, OP_SLLV, 32'h0000_0100, 1'b0, 1'b0, "sllv");
        op_k(32'h0000_0000, 32'h0F0F_0F0F, OP_NOT, 32'hF0F0_F0F0, 1'b0, 1'b0, "not");
        op_k(32'hC000_0001, 32'h0, OP_SLL1, 32'h8000_0002, 1'b0, 1'b0, "sll1");
        op_k(32'h5, 32'h6, OP_BNE, 32'h0, 1'b0, 1'b1, "bne");
        op_k(32'h5, 32'h6, OP_BEQ, 32'h0, 1'b0, 1'b0, "beq_ne");
        op_k(32'h1234_5678, 32'h1111_1111, OP_RSVD, 32'h0, 1'b0, 1'b0, "rsvd");
        op_k(32'hFFFF_FFFF, 32'h1, OP_ADD, 32'h0, 1'b0, 1'b0, "add_wrap");
        op_k(32'h0001_0003, 32'h0000_0005, OP_MUL, 32'h0005_000F, 1'b0, 1'b0, "mul_small");
        op_k(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL, 32'h1, 1'b0, 1'b0, "mul_ones");

        // Random ops checked against the reference model.
        for (int i = 0; i < 30; i++) begin
            op_m($urandom, $urandom, 4'($urandom_range(0, 15)), "rand");
        end

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        e.f = 32'h0;
        e.ovf = 1'b0;
        e.zero = 1'b1;
        sb_q.push_back(e);
        send(32'h7, 32'h7, OP_BEQ);
        for (int i = 0; i < 3; i++) begin
            check_val("bp_out_valid", out_valid, 1);
            check_val("bp_f", f, 0);
            check_val("bp_zero", zero, 1);
            check_val("bp_in_ready", in_ready, 0);
            tick();
        end
        // Take the result and accept a new op in the same cycle.
        a = 32'h0000_F0F0;
        b = 32'h0000_FF00;
        sel = OP_AND;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val("b2b_in_ready", in_ready, 1);
        expect_res("beq_held", 1, 1'b0);
        e.f = 32'h0000_F000;
        e.ovf = 1'b0;
        e.zero = 1'b0;
        sb_q.push_back(e);
        tick();
        in_valid = 1'b0;
        expect_res("and_b2b", 1, 1'b0);
        tick();

        // Asynchronous reset during BUSY cycle 10 of a multiply.
        send(32'h3, 32'h5, OP_MUL);
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_f", f, 0);
        check_val("midrst_in_ready", in_ready, 1);
        #3 rst_n = 1'b1;
        tick();
        check_val("postrst_out_valid", out_valid, 0);
        check_val("postrst_f", f, 0);
        check_val("postrst_in_ready", in_ready, 1);
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) hi_cnt++;
            tick();
        end
        check_val("no_stale_result", hi_cnt, 0);
        op_k(32'h2, 32'h3, OP_ADD, 32'h5, 1'b0, 1'b0, "after_rst_add");

        check_val("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
